// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hazard_pkg
// Description : Shared types and checks for the hazard scoreboard.
//               - entry_t      : one tracked in-flight instruction
//               - FWD_NONE     : select value meaning "read the register file"
//               - params_legal : parameter legality check used at elaboration
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Widest register address the scoreboard can hold. Narrower addresses are
  // zero-extended into the entry so the struct does not need a parameter.
  localparam int unsigned MAX_REG_AW = 8;

  localparam int unsigned FWD_NONE = 0;

  typedef logic [MAX_REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      wen;
    reg_addr_t waddr;
    logic      is_load;
    logic      is_branch;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

  function automatic bit params_legal(
    input int unsigned reg_aw,
    input int unsigned stages,
    input int unsigned load_ready,
    input int unsigned br_stage
  );
    return (reg_aw >= 1) && (reg_aw <= MAX_REG_AW) &&
           (stages >= 2) &&
           (load_ready >= 1) && (load_ready <= stages) &&
           (br_stage < stages);
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hazard_cmp
// Description : Priority match of one source operand against all tracked
//               pipeline entries. The youngest (lowest index) matching entry
//               decides the result.
// Ports       : en_i       operand is live (valid, used, non-zero address)
//               addr_i     zero-extended source register address
//               entries_i  tracked entries, index 0 = youngest
//               sel_o      0 = register file, k = forward from stage k-1
//               hazard_o   matching producer is a load not yet forwardable
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                      en_i,
  input  reg_addr_t                 addr_i,
  input  entry_t [STAGES-1:0]       entries_i,
  output logic     [SEL_W-1:0]      sel_o,
  output logic                      hazard_o
);

  // Scan oldest to youngest so the last hit (the youngest) overrides.
  always_comb begin
    sel_o    = SEL_W'(FWD_NONE);
    hazard_o = 1'b0;
    if (en_i) begin
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
        if (entries_i[k].valid && entries_i[k].wen &&
            (entries_i[k].waddr == addr_i)) begin
          hazard_o = entries_i[k].is_load && (k < int'(LOAD_READY));
          sel_o    = hazard_o ? SEL_W'(FWD_NONE) : SEL_W'(k + 1);
        end
      end
    end
  end

endmodule : hazard_cmp
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller. Tracks the destination,
//               load flag and branch flag of each instruction in the STAGES
//               stages after ID and derives forwarding selects, the load-use
//               stall and the branch-taken flush.
// Ports       : clk_i             clock
//               rst_ni            synchronous active-low reset
//               pipe_en_i         advance enable, low freezes all state
//               id_*_i            ID-stage instruction description
//               br_taken_i        branch in stage BR_STAGE resolved taken
//               fwd_rs/rt_sel_o   0 = regfile, k = forward from stage k-1
//               stall_o           hold IF/ID, bubble into stage 0
//               flush_if/id_o     kill IF and ID contents
//               stg_valid_o       valid bit of each tracked entry
//               br_pending_o      valid branch in ID or below BR_STAGE
//               br_err_o          sticky: taken without a valid branch
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned BR_STAGE   = 1,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_en_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_wen_i,
  input  logic [REG_AW-1:0] id_waddr_i,
  input  logic              id_is_load_i,
  input  logic              id_is_branch_i,
  input  logic              br_taken_i,
  output logic [SEL_W-1:0]  fwd_rs_sel_o,
  output logic [SEL_W-1:0]  fwd_rt_sel_o,
  output logic              stall_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic [STAGES-1:0] stg_valid_o,
  output logic              br_pending_o,
  output logic              br_err_o
);

  generate
    if (!params_legal(REG_AW, STAGES, LOAD_READY, BR_STAGE)) begin : g_param_check
      $error("hazard_scoreboard: illegal parameter combination");
    end
  endgenerate

  entry_t [STAGES-1:0] entries_q, entries_d;
  logic                br_err_q, br_err_d;

  logic             rs_en, rt_en;
  logic [SEL_W-1:0] rs_sel_raw, rt_sel_raw;
  logic             rs_haz, rt_haz;
  logic             flush;

  // ---------------------------------------------------------------------------
  // Operand matching
  // ---------------------------------------------------------------------------
  assign rs_en = id_valid_i & id_uses_rs_i & (id_rs_i != '0);
  assign rt_en = id_valid_i & id_uses_rt_i & (id_rt_i != '0);

  hazard_cmp #(
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_cmp_rs (
    .en_i      (rs_en),
    .addr_i    (reg_addr_t'(id_rs_i)),
    .entries_i (entries_q),
    .sel_o     (rs_sel_raw),
    .hazard_o  (rs_haz)
  );

  hazard_cmp #(
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_cmp_rt (
    .en_i      (rt_en),
    .addr_i    (reg_addr_t'(id_rt_i)),
    .entries_i (entries_q),
    .sel_o     (rt_sel_raw),
    .hazard_o  (rt_haz)
  );

  // ---------------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------------
  // A taken branch only acts while the pipe advances. When frozen, the stall
  // keeps evaluating against the held state so the hold persists.
  assign flush        = br_taken_i & pipe_en_i;
  assign stall_o      = (rs_haz | rt_haz) & ~flush;
  assign flush_if_o   = flush;
  assign flush_id_o   = flush;
  assign fwd_rs_sel_o = stall_o ? SEL_W'(FWD_NONE) : rs_sel_raw;
  assign fwd_rt_sel_o = stall_o ? SEL_W'(FWD_NONE) : rt_sel_raw;
  assign br_err_o     = br_err_q;

  always_comb begin
    br_pending_o = id_valid_i & id_is_branch_i;
    for (int k = 0; k < int'(STAGES); k++) begin
      if ((k < int'(BR_STAGE)) && entries_q[k].valid && entries_q[k].is_branch) begin
        br_pending_o = 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stg_valid
      assign stg_valid_o[g] = entries_q[g].valid;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    entries_d = entries_q;
    br_err_d  = br_err_q;
    if (pipe_en_i) begin
      // Entries younger than the branch are on the wrong path: they must not
      // move forward, so every slot they would shift into (1..BR_STAGE)
      // receives a bubble. The branch itself and older entries advance.
      for (int k = int'(STAGES) - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
        if (flush && (k <= int'(BR_STAGE))) begin
          entries_d[k] = ENTRY_BUBBLE;
        end
      end

      if (flush || stall_o || !id_valid_i) begin
        entries_d[0] = ENTRY_BUBBLE;
      end else begin
        entries_d[0] = '{valid:     1'b1,
                         wen:       id_wen_i,
                         waddr:     reg_addr_t'(id_waddr_i),
                         is_load:   id_is_load_i,
                         is_branch: id_is_branch_i};
      end

      if (flush && !(entries_q[BR_STAGE].valid && entries_q[BR_STAGE].is_branch)) begin
        br_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entries_q <= '0;
      br_err_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      br_err_q  <= br_err_d;
    end
  end

endmodule : hazard_scoreboard
`default_nettype wire
